// File: rtl/beep_sequencer_if.sv
// Pattern request and buzzer drive bundle between the alarm controller and beep_sequencer.
// The master side issues requests; the slave side is the sequencer.
interface beep_sequencer_if;
  logic        start_i;
  logic        stop_i;
  logic [3:0]  count_i;
  logic [9:0]  on_ms_i;
  logic [9:0]  off_ms_i;
  logic [21:0] tone_i;
  logic        busy_o;
  logic        done_o;
  logic        buzz_en_o;
  logic [21:0] buzz_cmp_o;

  modport master (
    output start_i, stop_i, count_i, on_ms_i, off_ms_i, tone_i,
    input  busy_o, done_o, buzz_en_o, buzz_cmp_o
  );

  modport slave (
    input  start_i, stop_i, count_i, on_ms_i, off_ms_i, tone_i,
    output busy_o, done_o, buzz_en_o, buzz_cmp_o
  );
endinterface

// File: rtl/beep_sequencer.sv
// Plays a latched pattern of count tone bursts (on_ms on, off_ms off) on the buzzer,
// then pulses done. stop aborts at any time without a done pulse.
module beep_sequencer #(
  parameter int TICK_DIV = 50000
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  beep_sequencer_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t      r_state, w_state_next;
  logic [PW-1:0] r_presc, w_presc_next;
  logic [9:0]  r_ms_cnt, w_ms_cnt_next;
  logic [3:0]  r_beeps_left, w_beeps_left_next;
  logic [9:0]  r_on_ms, w_on_ms_next;
  logic [9:0]  r_off_ms, w_off_ms_next;
  logic [21:0] r_tone, w_tone_next;
  logic        r_busy, r_done, r_buzz_en;
  logic        w_done_next;
  logic        w_ms_tick;
  logic [9:0]  w_phase_ms;

  assign w_ms_tick  = (r_presc == PW'(TICK_DIV - 1));
  assign w_phase_ms = (r_state == S_ON) ? r_on_ms : r_off_ms;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_ms_cnt     <= '0;
      r_beeps_left <= '0;
      r_on_ms      <= '0;
      r_off_ms     <= '0;
      r_tone       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_buzz_en    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_presc      <= w_presc_next;
      r_ms_cnt     <= w_ms_cnt_next;
      r_beeps_left <= w_beeps_left_next;
      r_on_ms      <= w_on_ms_next;
      r_off_ms     <= w_off_ms_next;
      r_tone       <= w_tone_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_done       <= w_done_next;
      r_buzz_en    <= (w_state_next == S_ON);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_presc_next      = r_presc;
    w_ms_cnt_next     = r_ms_cnt;
    w_beeps_left_next = r_beeps_left;
    w_on_ms_next      = r_on_ms;
    w_off_ms_next     = r_off_ms;
    w_tone_next       = r_tone;
    w_done_next       = 1'b0;

    if (bus.stop_i) begin
      // Abort: latched pattern and tone are kept, only the sequencing state is cleared.
      w_state_next      = S_IDLE;
      w_presc_next      = '0;
      w_ms_cnt_next     = '0;
      w_beeps_left_next = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            // Zero durations are clamped to 1 ms so each phase always has length.
            w_on_ms_next  = (bus.on_ms_i == 10'd0) ? 10'd1 : bus.on_ms_i;
            w_off_ms_next = (bus.off_ms_i == 10'd0) ? 10'd1 : bus.off_ms_i;
            w_tone_next   = bus.tone_i;
            w_presc_next  = '0;
            w_ms_cnt_next = '0;
            if (bus.count_i != 4'd0) begin
              w_beeps_left_next = bus.count_i;
              w_state_next      = S_ON;
            end else begin
              w_done_next = 1'b1;
            end
          end
        end
        S_ON, S_OFF: begin
          w_presc_next = w_ms_tick ? '0 : r_presc + PW'(1);
          if (w_ms_tick) begin
            if (r_ms_cnt == w_phase_ms - 10'd1) begin
              w_ms_cnt_next = '0;
              if (r_state == S_OFF) begin
                w_state_next = S_ON;
              end else begin
                w_beeps_left_next = r_beeps_left - 4'd1;
                if (r_beeps_left == 4'd1) begin
                  w_state_next = S_IDLE;
                  w_done_next  = 1'b1;
                end else begin
                  w_state_next = S_OFF;
                end
              end
            end else begin
              w_ms_cnt_next = r_ms_cnt + 10'd1;
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.buzz_en_o  = r_buzz_en;
  assign bus.buzz_cmp_o = r_tone;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with TICK_DIV=4: each segment is checked cycle by cycle
// against hand-derived {busy, buzz_en, done} levels.
module tb_beep_sequencer;

  logic clk_i;
  logic rst_n_i;
  int   n_total;
  int   n_bad;

  beep_sequencer_if bif ();

  beep_sequencer #(.TICK_DIV(4)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bif.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({bif.busy_o, bif.buzz_en_o, bif.done_o});
  endfunction

  // Checks n consecutive cycles for fixed busy/en/done levels, advancing one clock each.
  task automatic seg(input string tag, input int n, input logic b, input logic e, input logic d);
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s[%0d]", tag, i), outs(), 32'({b, e, d}));
      step();
    end
  endtask

  task automatic start_pat(input logic [3:0] c, input logic [9:0] on_ms,
                           input logic [9:0] off_ms, input logic [21:0] tone);
    bif.count_i  = c;
    bif.on_ms_i  = on_ms;
    bif.off_ms_i = off_ms;
    bif.tone_i   = tone;
    bif.start_i  = 1'b1;
    step();
    bif.start_i  = 1'b0;
  endtask

  initial begin
    n_total      = 0;
    n_bad        = 0;
    rst_n_i      = 1'b0;
    bif.start_i  = 1'b0;
    bif.stop_i   = 1'b0;
    bif.count_i  = '0;
    bif.on_ms_i  = '0;
    bif.off_ms_i = '0;
    bif.tone_i   = '0;
    step();
    check_val("rst_outs", outs(), 32'd0);
    check_val("rst_cmp", 32'(bif.buzz_cmp_o), 32'd0);
    step();
    rst_n_i = 1'b1;
    step();
    seg("idle0", 2, 0, 0, 0);

    // 3 beeps, 2 ms on, 1 ms off
    start_pat(4'd3, 10'd2, 10'd1, 22'd100);
    check_val("t1_cmp", 32'(bif.buzz_cmp_o), 32'd100);
    seg("t1_on1", 8, 1, 1, 0);
    seg("t1_off1", 4, 1, 0, 0);
    seg("t1_on2", 8, 1, 1, 0);
    seg("t1_off2", 4, 1, 0, 0);
    seg("t1_on3", 8, 1, 1, 0);
    seg("t1_done", 1, 0, 0, 1);
    seg("t1_idle", 2, 0, 0, 0);

    // count=0: no beep, done next cycle
    start_pat(4'd0, 10'd2, 10'd1, 22'd33);
    seg("t2_done", 1, 0, 0, 1);
    seg("t2_idle", 3, 0, 0, 0);
    check_val("t2_cmp", 32'(bif.buzz_cmp_o), 32'd33);

    // zero durations clamp to 1 ms
    start_pat(4'd2, 10'd0, 10'd0, 22'd55);
    seg("t3_on1", 4, 1, 1, 0);
    seg("t3_off1", 4, 1, 0, 0);
    seg("t3_on2", 4, 1, 1, 0);
    seg("t3_done", 1, 0, 0, 1);
    seg("t3_idle", 1, 0, 0, 0);

    // stop on the 3rd cycle of the second beep
    start_pat(4'd3, 10'd2, 10'd1, 22'd100);
    seg("t4_on1", 8, 1, 1, 0);
    seg("t4_off1", 4, 1, 0, 0);
    seg("t4_on2", 2, 1, 1, 0);
    check_val("t4_pre_stop", outs(), 32'd6);
    bif.stop_i = 1'b1;
    step();
    bif.stop_i = 1'b0;
    seg("t4_stopped", 4, 0, 0, 0);
    check_val("t4_cmp", 32'(bif.buzz_cmp_o), 32'd100);

    // start during OFF is ignored
    start_pat(4'd2, 10'd1, 10'd2, 22'd100);
    seg("t5_on1", 4, 1, 1, 0);
    seg("t5_off1a", 2, 1, 0, 0);
    bif.start_i = 1'b1;
    bif.tone_i  = 22'd200;
    bif.count_i = 4'd5;
    seg("t5_off1b", 1, 1, 0, 0);
    bif.start_i = 1'b0;
    seg("t5_off1c", 5, 1, 0, 0);
    seg("t5_on2", 4, 1, 1, 0);
    seg("t5_done", 1, 0, 0, 1);
    check_val("t5_cmp", 32'(bif.buzz_cmp_o), 32'd100);

    // start+stop together in IDLE: nothing happens
    bif.tone_i  = 22'd300;
    bif.count_i = 4'd2;
    bif.start_i = 1'b1;
    bif.stop_i  = 1'b1;
    step();
    bif.start_i = 1'b0;
    bif.stop_i  = 1'b0;
    seg("t5_ss", 3, 0, 0, 0);
    check_val("t5_ss_cmp", 32'(bif.buzz_cmp_o), 32'd100);

    // asynchronous reset during ON
    start_pat(4'd3, 10'd2, 10'd1, 22'd77);
    seg("t6_on1", 3, 1, 1, 0);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_val("t6_async_outs", outs(), 32'd0);
    check_val("t6_async_cmp", 32'(bif.buzz_cmp_o), 32'd0);
    step();
    step();
    rst_n_i = 1'b1;
    step();
    seg("t6_idle", 1, 0, 0, 0);
    start_pat(4'd1, 10'd1, 10'd1, 22'd9);
    seg("t6_on", 4, 1, 1, 0);
    seg("t6_done", 1, 0, 0, 1);
    seg("t6_idle2", 1, 0, 0, 0);
    check_val("t6_cmp", 32'(bif.buzz_cmp_o), 32'd9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
